pipe_skid_buf: RTL and testbench

PIPE_SKID_BUF -- requirements
Module: pipe_skid_buf

---
 rtl/pipe_skid_buf_pkg.sv | 28 ++
 rtl/pipe_skid_stage.sv | 87 ++++++++
 rtl/pipe_skid_buf.sv | 73 +++++++
 tb/tb_pipe_skid_buf.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_buf_pkg.sv
// Shared definitions for the skid-buffer pipeline: stage state encoding,
// parameter limits and the state-to-occupancy mapping.
package pipe_skid_buf_pkg;

    localparam int unsigned STAGES_MIN = 1;
    localparam int unsigned STAGES_MAX = 4;
    localparam int unsigned DATA_W_MIN = 1;
    localparam int unsigned DATA_W_MAX = 128;

    // Width of one stage's occupancy (0, 1 or 2 entries)
    localparam int unsigned OCC_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } skid_state_e;

    // Number of entries held by a stage in the given state
    function automatic logic [OCC_W-1:0] occupancy(input skid_state_e st);
        case (st)
            ST_ONE:  return OCC_W'(1);
            ST_TWO:  return OCC_W'(2);
            default: return OCC_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// One skid stage: a main register feeding the output and a skid register
// that absorbs a single word of backpressure, so ready depends only on state.
module pipe_skid_stage
    import pipe_skid_buf_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [OCC_W-1:0]  occ_d_o
);

    skid_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_fire;
    logic              out_fire;

    assign in_ready_o  = (state_q != ST_TWO);
    assign out_valid_o = (state_q != ST_EMPTY);
    assign out_data_o  = main_q;

    // A flush suppresses the input transfer; the output side simply empties
    assign in_fire  = in_valid_i & in_ready_o & ~flush_i;
    assign out_fire = out_valid_o & out_ready_i;

    assign occ_d_o = occupancy(state_d);

    // Next state and data register loads
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = in_data_i;
                    end
                end
                ST_ONE: begin
                    if (in_fire && !out_fire) begin
                        state_d = ST_TWO;
                        skid_d  = in_data_i;
                    end else if (!in_fire && out_fire) begin
                        state_d = ST_EMPTY;
                    end else if (in_fire && out_fire) begin
                        main_d = in_data_i;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and data registers; data survives a flush, only reset clears it
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/pipe_skid_buf.sv
// Cascade of STAGES skid stages with a registered total occupancy count.
module pipe_skid_buf
    import pipe_skid_buf_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STAGES = 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             flush_i,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic [DATA_W-1:0]                in_data_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [DATA_W-1:0]                out_data_o,
    output logic [$clog2(2*STAGES+1)-1:0]    count_o
);

    localparam int unsigned CNT_W = $clog2(2*STAGES+1);

    // Handshake chain: index k is the input of stage k, index STAGES the output
    logic [STAGES:0]              ch_valid;
    logic [STAGES:0]              ch_ready;
    logic [STAGES:0][DATA_W-1:0]  ch_data;
    logic [STAGES-1:0][OCC_W-1:0] occ_d;
    logic [CNT_W-1:0]             count_q, count_d;

    assign ch_valid[0]      = in_valid_i;
    assign ch_data[0]       = in_data_i;
    assign ch_ready[STAGES] = out_ready_i;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_skid_stage #(
            .DATA_W (DATA_W)
        ) u_stage (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .flush_i     (flush_i),
            .in_valid_i  (ch_valid[k]),
            .in_ready_o  (ch_ready[k]),
            .in_data_i   (ch_data[k]),
            .out_valid_o (ch_valid[k+1]),
            .out_ready_i (ch_ready[k+1]),
            .out_data_o  (ch_data[k+1]),
            .occ_d_o     (occ_d[k])
        );
    end

    // Upstream ready is held low during reset and flush
    assign in_ready_o  = rst_i & ~flush_i & ch_ready[0];
    assign out_valid_o = ch_valid[STAGES];
    assign out_data_o  = ch_data[STAGES];
    assign count_o     = count_q;

    // Total occupancy after this edge, summed from every stage
    always_comb begin
        count_d = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            count_d = count_d + CNT_W'(occ_d[k]);
        end
    end

    // Registered occupancy count
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Bench for pipe_skid_buf: three configurations share one stimulus, the
// selected one is compared against a per-stage occupancy model and an
// in-order scoreboard of accepted words.
`timescale 1ns/1ps
module tb_pipe_skid_buf;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic        d1_in_ready, d1_out_valid;
    logic [31:0] d1_out_data;
    logic [1:0]  d1_count;
    logic        d2_in_ready, d2_out_valid;
    logic [31:0] d2_out_data;
    logic [2:0]  d2_count;
    logic        d3_in_ready, d3_out_valid;
    logic [7:0]  d3_out_data;
    logic [2:0]  d3_count;

    logic        obs_in_ready, obs_out_valid;
    logic [31:0] obs_out_data;
    logic [3:0]  obs_count;

    int          sel = 1;
    int          checks = 0;
    int          errors = 0;

    // Reference model: per-stage FIFO of up to two words
    int          m_S = 1;
    logic [31:0] m_mask = 32'hFFFF_FFFF;
    int          m_occ [4];
    logic [31:0] m_ent [4][2];
    logic [31:0] sb [$];
    logic        seen55 = 1'b0;

    always #5 clk = ~clk;

    pipe_skid_buf #(.DATA_W(32), .STAGES(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(d1_in_ready), .in_data_i(in_data),
        .out_valid_o(d1_out_valid), .out_ready_i(out_ready), .out_data_o(d1_out_data),
        .count_o(d1_count)
    );

    pipe_skid_buf #(.DATA_W(32), .STAGES(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(d2_in_ready), .in_data_i(in_data),
        .out_valid_o(d2_out_valid), .out_ready_i(out_ready), .out_data_o(d2_out_data),
        .count_o(d2_count)
    );

    pipe_skid_buf #(.DATA_W(8), .STAGES(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(d3_in_ready), .in_data_i(in_data[7:0]),
        .out_valid_o(d3_out_valid), .out_ready_i(out_ready), .out_data_o(d3_out_data),
        .count_o(d3_count)
    );

    always_comb begin
        obs_in_ready  = d2_in_ready;
        obs_out_valid = d2_out_valid;
        obs_out_data  = d2_out_data;
        obs_count     = 4'(d2_count);
        case (sel)
            1: begin
                obs_in_ready  = d1_in_ready;
                obs_out_valid = d1_out_valid;
                obs_out_data  = d1_out_data;
                obs_count     = 4'(d1_count);
            end
            3: begin
                obs_in_ready  = d3_in_ready;
                obs_out_valid = d3_out_valid;
                obs_out_data  = 32'(d3_out_data);
                obs_count     = 4'(d3_count);
            end
            default: ;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_count();
        int s = 0;
        for (int k = 0; k < m_S; k++) s += m_occ[k];
        return s;
    endfunction

    // Advance the model by one edge from the pre-edge contents and inputs
    task automatic model_step(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
        logic [31:0] h [4];
        logic        inf [4];
        logic        outf [4];
        if (fl) begin
            for (int k = 0; k < 4; k++) m_occ[k] = 0;
            sb.delete();
            return;
        end
        for (int k = 0; k < m_S; k++) begin
            h[k]    = m_ent[k][0];
            outf[k] = (m_occ[k] > 0) && ((k == m_S - 1) ? ordy : (m_occ[k+1] < 2));
        end
        for (int k = 0; k < m_S; k++) begin
            inf[k] = (k == 0) ? (iv && (m_occ[0] < 2)) : outf[k-1];
        end
        for (int k = 0; k < m_S; k++) begin
            if (outf[k]) begin
                m_ent[k][0] = m_ent[k][1];
                m_occ[k]--;
            end
            if (inf[k]) begin
                m_ent[k][m_occ[k]] = (k == 0) ? (d & m_mask) : h[k-1];
                m_occ[k]++;
            end
        end
    endtask

    // One clock: drive, compare against the model, then take the edge
    task automatic cycle(input logic iv, input logic [31:0] d, input logic ordy, input logic fl,
                         output logic acc);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_eq("in_ready", 32'(obs_in_ready), 32'((m_occ[0] < 2) && !fl));
        check_eq("out_valid", 32'(obs_out_valid), 32'(m_occ[m_S-1] > 0));
        check_eq("count", 32'(obs_count), 32'(model_count()));
        if (m_occ[m_S-1] > 0) check_eq("out_data", obs_out_data, m_ent[m_S-1][0]);
        out_ready = ~ordy;
        #1;
        check_eq("in_ready_vs_out_ready", 32'(obs_in_ready), 32'((m_occ[0] < 2) && !fl));
        out_ready = ordy;
        #1;
        acc = iv && (m_occ[0] < 2) && !fl;
        if (obs_out_valid && ordy) begin
            if (obs_out_data == 32'h55) seen55 = 1'b1;
            if (!fl) begin
                check_eq("sb_avail", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) check_eq("sb_order", obs_out_data, sb.pop_front());
            end
        end
        if (acc) sb.push_back(d & m_mask);
        @(posedge clk);
        #1;
        model_step(iv, d, ordy, fl);
    endtask

    task automatic do_reset(input int s);
        sel    = s;
        m_S    = (s == 2) ? 2 : ((s == 3) ? 3 : 1);
        m_mask = (s == 3) ? 32'h0000_00FF : 32'hFFFF_FFFF;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #2;
        check_eq("rst_in_ready", 32'(obs_in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(obs_out_valid), 32'd0);
        check_eq("rst_out_data", obs_out_data, 32'd0);
        check_eq("rst_count", 32'(obs_count), 32'd0);
        for (int k = 0; k < 4; k++) m_occ[k] = 0;
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   n;

        // Single stage streaming at full rate
        do_reset(1);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 32'h11 + 32'(i), 1'b1, 1'b0, acc);
            check_eq("s1_stream_valid", 32'(obs_out_valid), 32'd1);
            check_eq("s1_stream_data", obs_out_data, 32'h11 + 32'(i));
            check_eq("s1_count_max", 32'(obs_count <= 4'd1), 32'd1);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, acc);
        check_eq("s1_drained", 32'(sb.size()), 32'd0);

        // Single stage backpressure, then drain in order
        do_reset(1);
        cycle(1'b1, 32'hA, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'hB, 1'b0, 1'b0, acc);
        check_eq("bp_count", 32'(obs_count), 32'd2);
        check_eq("bp_in_ready", 32'(obs_in_ready), 32'd0);
        cycle(1'b1, 32'hC, 1'b0, 1'b0, acc);
        check_eq("bp_full_data", obs_out_data, 32'hA);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        check_eq("bp_second", obs_out_data, 32'hB);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, acc);
        check_eq("bp_drained", 32'(sb.size()), 32'd0);

        // Asynchronous reset between edges with two entries held
        do_reset(1);
        cycle(1'b1, 32'h1, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h2, 1'b0, 1'b0, acc);
        check_eq("ar_count_before", 32'(obs_count), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check_eq("ar_out_valid", 32'(obs_out_valid), 32'd0);
        check_eq("ar_count", 32'(obs_count), 32'd0);
        check_eq("ar_in_ready", 32'(obs_in_ready), 32'd0);

        // Three stages, 8-bit: fill to six, then drain
        do_reset(3);
        for (int i = 0; i < 6; i++) begin
            acc = 1'b0;
            n = 0;
            while (!acc && n < 20) begin
                cycle(1'b1, 32'hC1 + 32'(i), 1'b0, 1'b0, acc);
                n++;
            end
            check_eq("fill_accept", 32'(acc), 32'd1);
        end
        check_eq("fill_count", 32'(obs_count), 32'd6);
        check_eq("fill_in_ready", 32'(obs_in_ready), 32'd0);
        cycle(1'b1, 32'hEE, 1'b0, 1'b0, acc);
        check_eq("fill_ignore", 32'(obs_count), 32'd6);
        for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1, 1'b0, acc);
        check_eq("fill_drained", 32'(sb.size()), 32'd0);

        // Flush with four held and 0x55 offered in the same cycle
        do_reset(3);
        seen55 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            acc = 1'b0;
            n = 0;
            while (!acc && n < 20) begin
                cycle(1'b1, 32'h31 + 32'(i), 1'b0, 1'b0, acc);
                n++;
            end
        end
        check_eq("fl_count_before", 32'(obs_count), 32'd4);
        cycle(1'b1, 32'h55, 1'b0, 1'b1, acc);
        check_eq("fl_count", 32'(obs_count), 32'd0);
        check_eq("fl_out_valid", 32'(obs_out_valid), 32'd0);
        cycle(1'b1, 32'h66, 1'b1, 1'b0, acc);
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b0, acc);
        check_eq("fl_no_55", 32'(seen55), 32'd0);
        check_eq("fl_drained", 32'(sb.size()), 32'd0);

        // Two stages under random valid/ready with occasional flush
        do_reset(2);
        for (int i = 0; i < 10000; i++) begin
            cycle(1'(($urandom % 4) != 0), $urandom, 1'(($urandom % 3) != 0),
                  1'(($urandom % 256) == 0), acc);
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b0, acc);
        check_eq("rnd_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
